data_stack: RTL and testbench

DATA_STACK -- requirements
Module: data_stack

---
 rtl/data_stack.sv | 92 +++++++++
 tb/tb_data_stack.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/data_stack.sv
// LIFO of DEPTH x WIDTH registers with a registered pop port, a combinational top-of-stack
// peek and sticky overflow/underflow flags. The stack pointer always equals the entry count.
module data_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_stack,
    input  logic             push_stack,
    input  logic             pop_stack,
    input  logic [WIDTH-1:0] stack_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [WIDTH-1:0] top_data,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   sp;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_idx;
    logic             wr_en;

    assign top_idx  = PTR_W'(sp - 1'b1);
    assign count    = sp;
    assign empty    = (sp == '0);
    assign full     = (sp == (PTR_W+1)'(DEPTH));
    // Stale memory is never exposed: an empty stack peeks as zero.
    assign top_data = empty ? '0 : mem[top_idx];

    // Write port: a simultaneous push/pop replaces the top entry in place.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = sp[PTR_W-1:0];
        if (!rst && !rst_stack && push_stack) begin
            if (pop_stack && !empty) begin
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end else if (!full) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= stack_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp        <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (rst_stack) begin
            sp        <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            if (push_stack && pop_stack) begin
                if (!empty) begin
                    pop_data  <= mem[top_idx];
                    pop_valid <= 1'b1;
                end else begin
                    underflow <= 1'b1;
                    sp        <= sp + 1'b1;
                end
            end else if (push_stack) begin
                if (!full) sp <= sp + 1'b1;
                else       overflow <= 1'b1;
            end else if (pop_stack) begin
                if (!empty) begin
                    pop_data  <= mem[top_idx];
                    pop_valid <= 1'b1;
                    sp        <= sp - 1'b1;
                end else begin
                    underflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_stack.sv
// Bench for data_stack: directed scenarios then randomized traffic, all checked against
// a queue-based reference model of the stack.
module tb_data_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 32;
    localparam int PTR_W = 5;

    logic             clk = 1'b0;
    logic             rst, rst_stack, push_stack, pop_stack;
    logic [WIDTH-1:0] stack_data;
    logic [WIDTH-1:0] pop_data, top_data;
    logic             pop_valid, full, empty, overflow, underflow;
    logic [PTR_W:0]   count;

    int vectors = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_pd;
    logic             m_pv, m_ovf, m_unf;

    always #5 clk = ~clk;

    data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .rst_stack(rst_stack), .push_stack(push_stack),
        .pop_stack(pop_stack), .stack_data(stack_data), .pop_data(pop_data),
        .pop_valid(pop_valid), .top_data(top_data), .count(count), .full(full),
        .empty(empty), .overflow(overflow), .underflow(underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stack semantics expressed on a queue whose back is the top of stack.
    task automatic model(input logic r, input logic rs, input logic pu, input logic po,
                         input logic [WIDTH-1:0] d);
        if (r) begin
            q.delete(); m_pd = '0; m_pv = 0; m_ovf = 0; m_unf = 0;
        end else if (rs) begin
            q.delete(); m_pv = 0; m_ovf = 0; m_unf = 0;
        end else begin
            m_pv = 0;
            if (pu && po) begin
                if (q.size() > 0) begin
                    m_pd = q[$]; q[$] = d; m_pv = 1;
                end else begin
                    m_unf = 1; q.push_back(d);
                end
            end else if (pu) begin
                if (q.size() < DEPTH) q.push_back(d);
                else m_ovf = 1;
            end else if (po) begin
                if (q.size() > 0) begin
                    m_pd = q.pop_back(); m_pv = 1;
                end else m_unf = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".top"}, 32'(top_data), (q.size() > 0) ? 32'(q[$]) : 32'h0);
        chk({tag, ".pop_data"}, 32'(pop_data), 32'(m_pd));
        chk({tag, ".pop_valid"}, 32'(pop_valid), 32'(m_pv));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic step(input string tag, input logic r, input logic rs, input logic pu,
                        input logic po, input logic [WIDTH-1:0] d);
        rst = r; rst_stack = rs; push_stack = pu; pop_stack = po; stack_data = d;
        @(posedge clk);
        #1;
        model(r, rs, pu, po, d);
        check_all(tag);
    endtask

    initial begin
        rst = 1; rst_stack = 0; push_stack = 0; pop_stack = 0; stack_data = '0;
        m_pd = '0; m_pv = 0; m_ovf = 0; m_unf = 0;

        // Reset state
        step("reset", 1, 0, 0, 0, '0);
        chk("reset.empty_const", 32'(empty), 32'h1);
        step("idle", 0, 0, 0, 0, '0);

        // Three pushes, three pops in LIFO order
        for (int i = 1; i <= 3; i++) step("r34_push", 0, 0, 1, 0, WIDTH'(i));
        for (int i = 3; i >= 1; i--) begin
            step("r34_pop", 0, 0, 0, 1, '0);
            chk("r34_pd_const", 32'(pop_data), 32'(i));
        end
        step("r34_idle", 0, 0, 0, 0, '0);

        // Fill to full then overflow
        for (int i = 0; i < DEPTH; i++) step("r35_fill", 0, 0, 1, 0, WIDTH'(16'h0100 + i));
        step("r35_ovf", 0, 0, 1, 0, 16'hBEEF);
        chk("r35_top_const", 32'(top_data), 32'h011F);
        step("r35_full_pp", 0, 0, 1, 1, 16'h1234);

        // Underflow, then push+pop on empty
        step("r36_clr", 0, 1, 0, 0, '0);
        step("r36_unf", 0, 0, 0, 1, '0);
        step("r36_pp_empty", 0, 0, 1, 1, 16'h00AA);
        chk("r36_top_const", 32'(top_data), 32'h00AA);

        // Push+pop swap with two entries
        step("r37_clr", 0, 1, 0, 0, '0);
        step("r37_push", 0, 0, 1, 0, 16'h0005);
        step("r37_push", 0, 0, 1, 0, 16'h0007);
        step("r37_swap", 0, 0, 1, 1, 16'h0009);
        chk("r37_pd_const", 32'(pop_data), 32'h0007);

        // rst_stack beats a same-cycle push while overflow is set
        step("r38_clr", 0, 1, 0, 0, '0);
        for (int i = 0; i < DEPTH; i++) step("r38_fill", 0, 0, 1, 0, WIDTH'(i));
        step("r38_ovf", 0, 0, 1, 0, 16'h7777);
        for (int i = 0; i < DEPTH - 3; i++) step("r38_drain", 0, 0, 0, 1, '0);
        step("r38_softclr", 0, 1, 1, 0, 16'h5555);
        step("r38_after", 0, 0, 0, 0, '0);

        // rst in the middle of a pop burst
        for (int i = 0; i < 4; i++) step("r39_push", 0, 0, 1, 0, WIDTH'(16'h0A00 + i));
        step("r39_pop", 0, 0, 0, 1, '0);
        step("r39_pop", 0, 0, 0, 1, '0);
        step("r39_rst", 1, 0, 1, 1, 16'hDEAD);
        chk("r39_pd_const", 32'(pop_data), 32'h0);

        // Randomized traffic with phases biased toward filling, balancing and draining
        for (int i = 0; i < 900; i++) begin
            int bias;
            logic r, rs, pu, po;
            bias = (i / 150) % 3 == 0 ? 80 : ((i / 150) % 3 == 1 ? 50 : 20);
            r  = ($urandom_range(0, 299) == 0);
            rs = ($urandom_range(0, 79) == 0);
            pu = ($urandom_range(0, 99) < bias);
            po = ($urandom_range(0, 99) < 100 - bias);
            step("rand", r, rs, pu, po, WIDTH'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
